// File: rtl/pipe_mem_pkg.sv
// Shared types and defaults for the IF/MEM single-port RAM arbiter.
// State encoding, default widths and the watchdog timeout default.
package pipe_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        INST = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle counter that pulses expire when a RAM access hangs.
// TIMEOUT of 0 disables the pulse entirely.
module mem_arb_watchdog
    import pipe_mem_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [CW-1:0] cnt;

    // Count waiting cycles; cleared whenever no access is in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt <= '0;
        end else if (en_i) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Fires in the cycle whose count step would reach TIMEOUT.
    assign expire_o = (TIMEOUT != 0) && en_i
                    && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and MEM stage.
// MEM (older instruction) wins; stall holds the pipe until all are done.
module pipe_mem_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              stall_o,
    output logic              err_o,
    output logic              ram_req_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    input  logic              ram_ack_i
);

    arb_state_t state;
    logic       data_done;
    logic       inst_done;
    logic       pend_d;
    logic       pend_i;
    logic       busy;
    logic       expire;

    assign pend_d  = (mem_read_i | mem_write_i) & ~data_done;
    assign pend_i  = if_req_i & ~inst_done;
    assign busy    = (state != IDLE);
    assign stall_o = pend_d | pend_i | busy;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (~busy),
        .en_i     (busy & ~ram_ack_i),
        .expire_o (expire)
    );

    // Arbitration FSM; all RAM-side and result outputs are registered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            data_done   <= 1'b0;
            inst_done   <= 1'b0;
            err_o       <= 1'b0;
            ram_req_o   <= 1'b0;
            ram_we_o    <= 1'b0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pend_d) begin
                        state       <= DATA;
                        ram_req_o   <= 1'b1;
                        ram_addr_o  <= mem_addr_i;
                        ram_wdata_o <= mem_wdata_i;
                        ram_we_o    <= mem_write_i;
                        if (mem_read_i && mem_write_i) begin
                            err_o <= 1'b1;
                        end
                    end else if (pend_i) begin
                        state      <= INST;
                        ram_req_o  <= 1'b1;
                        ram_addr_o <= if_addr_i;
                        ram_we_o   <= 1'b0;
                    end else begin
                        data_done <= 1'b0;
                        inst_done <= 1'b0;
                    end
                end
                DATA: begin
                    if (ram_ack_i) begin
                        if (!ram_we_o) begin
                            mem_rdata_o <= ram_rdata_i;
                        end
                        data_done <= 1'b1;
                        state     <= IDLE;
                        ram_req_o <= 1'b0;
                        ram_we_o  <= 1'b0;
                    end else if (expire) begin
                        err_o     <= 1'b1;
                        data_done <= 1'b1;
                        state     <= IDLE;
                        ram_req_o <= 1'b0;
                        ram_we_o  <= 1'b0;
                    end
                end
                INST: begin
                    if (ram_ack_i) begin
                        if_rdata_o <= ram_rdata_i;
                        inst_done  <= 1'b1;
                        state      <= IDLE;
                        ram_req_o  <= 1'b0;
                    end else if (expire) begin
                        err_o     <= 1'b1;
                        inst_done <= 1'b1;
                        state     <= IDLE;
                        ram_req_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    ram_req_o <= 1'b0;
                    ram_we_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Bench for pipe_mem_arbiter: RAM model with programmable wait states
// and a transaction-level reference for stall length and results.
module tb_pipe_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          if_req_i = 1'b0;
    logic [AW-1:0] if_addr_i = '0;
    logic          mem_read_i = 1'b0;
    logic          mem_write_i = 1'b0;
    logic [AW-1:0] mem_addr_i = '0;
    logic [DW-1:0] mem_wdata_i = '0;
    logic [DW-1:0] if_rdata_o;
    logic [DW-1:0] mem_rdata_o;
    logic          stall_o;
    logic          err_o;
    logic          ram_req_o;
    logic          ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [DW-1:0] ram_wdata_o;
    logic [DW-1:0] ram_rdata_i = '0;
    logic          ram_ack_i = 1'b0;

    always #5 clk = ~clk;

    pipe_mem_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .mem_addr_i  (mem_addr_i),
        .mem_wdata_i (mem_wdata_i),
        .if_rdata_o  (if_rdata_o),
        .mem_rdata_o (mem_rdata_o),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .ram_req_o   (ram_req_o),
        .ram_we_o    (ram_we_o),
        .ram_addr_o  (ram_addr_o),
        .ram_wdata_o (ram_wdata_o),
        .ram_rdata_i (ram_rdata_i),
        .ram_ack_i   (ram_ack_i)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] ram [128];
    logic [31:0] mdl [128];
    int          wait_cycles = 0;
    bit          mute = 1'b0;
    int          busy_n = 0;
    int          req_cycles = 0;
    logic [32:0] acc_q [$];

    logic [31:0] exp_ird = '0;
    logic [31:0] exp_mrd = '0;
    logic        exp_err = 1'b0;

    // RAM model: acks after wait_cycles extra request cycles.
    always @(negedge clk) begin
        ram_ack_i = 1'b0;
        if (ram_req_o) begin
            req_cycles++;
            if (!mute && busy_n == wait_cycles) begin
                ram_ack_i = 1'b1;
                acc_q.push_back({ram_we_o, ram_addr_o});
                if (ram_we_o) ram[ram_addr_o[8:2]] = ram_wdata_o;
                else ram_rdata_i = ram[ram_addr_o[8:2]];
                busy_n = 0;
            end else begin
                busy_n++;
            end
        end else begin
            busy_n = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One pipeline cycle: drive requests, wait for stall to drop, check.
    task automatic xact(input bit rd, input bit wr,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit ifr, input logic [31:0] pc,
                        input int w, input bit mute_i);
        int n;
        int nacc;
        int exp_stall;
        int exp_req;
        logic [32:0] exp_q [$];
        exp_q.delete();
        nacc = int'(rd | wr) + int'(ifr);
        if (mute_i) begin
            exp_stall = nacc * (TO + 1);
            exp_req   = nacc * TO;
            if (nacc > 0) exp_err = 1'b1;
        end else begin
            exp_stall = nacc * (w + 2);
            exp_req   = nacc * (w + 1);
            if (rd | wr) exp_q.push_back({wr, a});
            if (ifr) exp_q.push_back({1'b0, pc});
            if (wr) mdl[a[8:2]] = wd;
            else if (rd) exp_mrd = mdl[a[8:2]];
            if (ifr) exp_ird = mdl[pc[8:2]];
            if (rd && wr) exp_err = 1'b1;
        end
        wait_cycles = w;
        mute        = mute_i;
        acc_q.delete();
        req_cycles  = 0;
        mem_read_i  = rd;
        mem_write_i = wr;
        mem_addr_i  = a;
        mem_wdata_i = wd;
        if_req_i    = ifr;
        if_addr_i   = pc;
        n = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (!stall_o) break;
            n++;
        end
        @(posedge clk);
        #1;
        mem_read_i  = 1'b0;
        mem_write_i = 1'b0;
        if_req_i    = 1'b0;
        mute        = 1'b0;
        chk("stall_cycles", 64'(n), 64'(exp_stall));
        chk("req_cycles", 64'(req_cycles), 64'(exp_req));
        chk("n_access", 64'(acc_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < acc_q.size()) chk("access", 64'(acc_q[i]), 64'(exp_q[i]));
        end
        chk("if_rdata", 64'(if_rdata_o), 64'(exp_ird));
        chk("mem_rdata", 64'(mem_rdata_o), 64'(exp_mrd));
        chk("err", 64'(err_o), 64'(exp_err));
        if (wr && !mute_i) chk("ram_word", 64'(ram[a[8:2]]), 64'(wd));
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rw;
        logic [31:0] rp;
        bit rrd;
        bit rwr;
        bit rif;
        for (int i = 0; i < 128; i++) begin
            ram[i] = $urandom;
            mdl[i] = ram[i];
        end
        ram[7'h10] = 32'h2002000A;
        mdl[7'h10] = 32'h2002000A;
        ram[7'h40] = 32'hDEADBEEF;
        mdl[7'h40] = 32'hDEADBEEF;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 64'(ram_req_o), 64'(0));
        chk("rst_we", 64'(ram_we_o), 64'(0));
        chk("rst_err", 64'(err_o), 64'(0));
        chk("rst_stall", 64'(stall_o), 64'(0));
        chk("rst_addr", 64'(ram_addr_o), 64'(0));
        chk("rst_if_rdata", 64'(if_rdata_o), 64'(0));
        chk("rst_mem_rdata", 64'(mem_rdata_o), 64'(0));
        rst_i = 1'b0;

        xact(0, 0, 32'h0, 32'h0, 1, 32'h40, 0, 0);
        xact(1, 0, 32'h100, 32'h0, 1, 32'h44, 0, 0);
        xact(0, 1, 32'h8, 32'h55, 0, 32'h0, 2, 0);
        xact(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            rrd = 1'($urandom_range(0, 1));
            rwr = rrd ? 1'b0 : 1'($urandom_range(0, 1));
            rif = 1'($urandom_range(0, 1));
            ra  = 32'($urandom_range(0, 127)) << 2;
            rp  = 32'($urandom_range(0, 127)) << 2;
            rw  = $urandom;
            xact(rrd, rwr, ra, rw, rif, rp, $urandom_range(0, 2), 0);
        end

        xact(1, 1, 32'h20, 32'hCAFEF00D, 1, 32'h24, 1, 0);
        xact(1, 0, 32'h10, 32'h0, 0, 32'h0, 0, 1);
        xact(0, 0, 32'h0, 32'h0, 1, 32'h40, 0, 0);

        mute       = 1'b1;
        mem_read_i = 1'b1;
        mem_addr_i = 32'h30;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("mid_req", 64'(ram_req_o), 64'(1));
        rst_i      = 1'b1;
        mem_read_i = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_req", 64'(ram_req_o), 64'(0));
        chk("mid_rst_stall", 64'(stall_o), 64'(0));
        chk("mid_rst_err", 64'(err_o), 64'(0));
        chk("mid_rst_addr", 64'(ram_addr_o), 64'(0));
        chk("mid_rst_we", 64'(ram_we_o), 64'(0));
        chk("mid_rst_wdata", 64'(ram_wdata_o), 64'(0));
        chk("mid_rst_if_rdata", 64'(if_rdata_o), 64'(0));
        chk("mid_rst_mem_rdata", 64'(mem_rdata_o), 64'(0));
        rst_i   = 1'b0;
        mute    = 1'b0;
        exp_err = 1'b0;
        exp_ird = '0;
        exp_mrd = '0;

        xact(1, 0, 32'h100, 32'h0, 1, 32'h40, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
Shares one single-ported instruction/data RAM between the IF stage (instruction fetch) and the MEM stage (load/store from the EX/MEM register outputs). The MEM stage has priority because it holds the older instruction. A global stall_o freezes all pipeline registers until every access requested in the current pipeline cycle has completed. A watchdog flags a RAM that never acknowledges.

Parameters:
ADDR_W, 32, address width for both requesters and the RAM.
DATA_W, 32, data width.
TIMEOUT, 255, maximum cycles to wait for ram_ack_i before aborting; 0 disables the watchdog.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  synchronous, active-high reset.
if_req_i  in  1  IF stage wants an instruction this pipeline cycle.
if_addr_i  in  ADDR_W  PC; held stable while stall_o=1.
mem_read_i  in  1  MemRead from EX/MEM.
mem_write_i  in  1  MemWrite from EX/MEM.
mem_addr_i  in  ADDR_W  ALU result from EX/MEM.
mem_wdata_i  in  DATA_W  store data from EX/MEM.
if_rdata_o  out  DATA_W  last fetched instruction (registered).
mem_rdata_o  out  DATA_W  last loaded data word (registered).
stall_o  out  1  freeze PC and all pipeline registers.
err_o  out  1  sticky: timeout or illegal read+write.
ram_req_o  out  1  RAM request; held until ack.
ram_we_o  out  1  write enable; valid while ram_req_o=1.
ram_addr_o  out  ADDR_W  registered RAM address.
ram_wdata_o  out  DATA_W  registered RAM write data.
ram_rdata_i  in  DATA_W  RAM read data; valid in the ack cycle.
ram_ack_i  in  1  one-cycle completion; may coincide with the first ram_req_o cycle.

Behaviour:
- Reset values: state=IDLE; ram_req_o, ram_we_o, err_o = 0; ram_addr_o, ram_wdata_o, if_rdata_o, mem_rdata_o = 0; done flags data_done, inst_done = 0; watchdog count = 0.
- States:
  - IDLE: no RAM access in progress.
  - DATA: servicing the MEM-stage access.
  - INST: servicing the instruction fetch.
- Pending terms (combinational):
  - pend_d = (mem_read_i | mem_write_i) & ~data_done
  - pend_i = if_req_i & ~inst_done
- IDLE transitions:
  - If pend_d, go to DATA and latch ram_addr_o=mem_addr_i, ram_wdata_o=mem_wdata_i, ram_we_o=mem_write_i.
  - Else if pend_i, go to INST and latch ram_addr_o=if_addr_i, ram_we_o=0.
  - Else stay in IDLE and clear data_done and inst_done (the pipeline advances this edge).
- ram_req_o = 1 exactly while in DATA or INST; it is driven from the state register, with no combinational path from the inputs.
- DATA with ram_ack_i:
  - On a read, mem_rdata_o <= ram_rdata_i.
  - data_done <= 1; state returns to IDLE.
- INST with ram_ack_i: if_rdata_o <= ram_rdata_i; inst_done <= 1; state returns to IDLE.
- stall_o = pend_d | pend_i | (state != IDLE). It is combinational and low only in an IDLE cycle with nothing pending.
- Latency with a zero-wait RAM (ack in the first req cycle):
  - Fetch only: stall_o is 1 for 2 cycles and the pipeline advances in cycle 3.
  - Load plus fetch: stall_o is 1 for 4 cycles; data is served first, then the instruction.
- Each extra RAM wait cycle adds 1 stall cycle.
- mem_read_i & mem_write_i both high: treated as a write and err_o <= 1.
- Watchdog:
  - The counter increments each busy cycle without ack and clears on entering DATA or INST.
  - When it reaches TIMEOUT, err_o <= 1, the matching done flag is set (the access is abandoned, read data is left unchanged), and state returns to IDLE.
- ram_ack_i in IDLE is ignored.
- err_o stays set until rst_i.
- Reset mid-access: state forced to IDLE and ram_req_o drops on the next edge; a late ack is ignored.
- Requester inputs changing while stall_o=1 is a protocol violation, and no behaviour is defined for it.

Decomposition:
- Shared package pipe_mem_pkg holds:
  - the state enum (IDLE, DATA, INST) and its 2-bit encoding;
  - the default widths;
  - the TIMEOUT default constant.
- One natural sub-module, mem_arb_watchdog: a counter with clear, enable and TIMEOUT compare, producing a one-cycle expire pulse.

Test Plan:
- Fetch only: if_req_i=1, PC=0x40, RAM returns 0x2002000A with zero wait → stall_o=1,1,0; if_rdata_o=0x2002000A; exactly one ram_req_o with ram_we_o=0 and ram_addr_o=0x40.
- Load + fetch: mem_read_i=1, addr 0x100, data 0xDEADBEEF; PC=0x44 → the first RAM access targets 0x100 and the second 0x44; mem_rdata_o=0xDEADBEEF; stall_o is high 4 cycles.
- Store with a 2-wait RAM: mem_write_i=1, addr 0x8, wdata 0x55 → ram_we_o=1 and ram_wdata_o=0x55 while req is held 3 cycles; mem_rdata_o unchanged.
- Timeout: TIMEOUT=4, RAM never acks → req held 4 cycles, then IDLE; err_o=1 sticky; the pipeline advances.
- Reset mid-access: rst_i pulsed in the second DATA cycle → next cycle ram_req_o=0, stall_o=0 with no requests pending, all outputs at reset values.
- Illegal read+write: both high → write performed and err_o=1.
